// File: rtl/bcd_sevenseg_counter_if.sv
// Control and display bundle for bcd_sevenseg_counter: count controls in,
// BCD count, segment drive and status pulses out.
interface bcd_sevenseg_counter_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;
  logic                  wrap;
  logic                  err;

  modport master (
    output en, up, load, load_value,
    input  bcd, seg, wrap, err
  );

  modport slave (
    input  en, up, load, load_value,
    output bcd, seg, wrap, err
  );
endinterface

// File: rtl/bcd_sevenseg_counter.sv
// Multi-digit BCD up/down counter with terminal-count wrap, validated load
// and registered seven-segment drive (optional leading-zero blanking).
module bcd_sevenseg_counter #(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned MAX_COUNT  = 63,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned LZ_BLANK   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_sevenseg_counter_if.slave   bus
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  p;
    r = '0;
    p = 1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (v[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (b) begin
        if (v[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
        else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A load is valid only when every nibble is a decimal digit and the value fits.
  function automatic logic load_ok(input logic [W-1:0] v);
    int unsigned acc;
    int unsigned d;
    logic        ok;
    acc = 0;
    ok  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = DIGITS - 1 - i;
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
      acc = acc * 10 + {28'd0, v[4*d +: 4]};
    end
    return ok && (acc <= MAX_COUNT);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0001100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Walk from the top digit down; zeros stay blank until the first nonzero digit.
  function automatic logic [7*DIGITS-1:0] encode(input logic [W-1:0] v);
    logic [7*DIGITS-1:0] s;
    logic [6:0]          p;
    logic                lead;
    int unsigned         d;
    s    = '0;
    lead = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = DIGITS - 1 - i;
      if (v[4*d +: 4] != 4'd0) lead = 1'b0;
      if (LZ_BLANK != 0 && lead && d != 0) p = 7'b1111111;
      else                                 p = seg7(v[4*d +: 4]);
      s[7*d +: 7] = (ACTIVE_LOW != 0) ? p : ~p;
    end
    return s;
  endfunction

  localparam logic [W-1:0]          MAX_BCD  = to_bcd(MAX_COUNT);
  localparam logic [7*DIGITS-1:0]   SEG_ZERO = encode('0);

  logic [W-1:0]          count, nxt;
  logic [7*DIGITS-1:0]   seg_q;
  logic                  wrap_q, err_q, wrap_n, err_n;

  always_comb begin
    nxt    = count;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (bus.load) begin
      if (load_ok(bus.load_value)) nxt = bus.load_value;
      else                         err_n = 1'b1;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count == MAX_BCD) begin
          nxt    = '0;
          wrap_n = 1'b1;
        end else nxt = bcd_inc(count);
      end else begin
        if (count == '0) begin
          nxt    = MAX_BCD;
          wrap_n = 1'b1;
        end else nxt = bcd_dec(count);
      end
    end
  end

  // Segments are encoded from the next count so they land on the same edge as bcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      seg_q  <= SEG_ZERO;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      count  <= nxt;
      seg_q  <= encode(nxt);
      wrap_q <= wrap_n;
      err_q  <= err_n;
    end
  end

  assign bus.bcd  = count;
  assign bus.seg  = seg_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_sevenseg_counter.sv
// Scoreboard bench: two counter configurations driven with directed and random
// stimulus, checked against an integer reference model.
module tb_bcd_sevenseg_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_sevenseg_counter_if #(.DIGITS(2)) b0 ();
  bcd_sevenseg_counter_if #(.DIGITS(3)) b1 ();

  bcd_sevenseg_counter u0 (.clk(clk), .rst(rst), .bus(b0));
  bcd_sevenseg_counter #(.DIGITS(3), .MAX_COUNT(999), .ACTIVE_LOW(0), .LZ_BLANK(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  localparam logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0001100};

  typedef struct { int c0; int c1; bit w0; bit e0; bit w1; bit e1; } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_bad = 0;
  int c0 = 0, c1 = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] exp_bcd(input int v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int d = 0; d < digits; d++) r[4*d +: 4] = 4'((v / (10**d)) % 10);
    return r;
  endfunction

  function automatic logic [63:0] exp_seg(input int v, input int digits, input bit al, input bit lz);
    logic [63:0] s;
    logic [6:0]  p;
    s = '0;
    for (int d = 0; d < digits; d++) begin
      if (lz && d > 0 && v < 10**d) p = 7'h7f;
      else                          p = PAT[(v / (10**d)) % 10];
      s[7*d +: 7] = al ? p : ~p;
    end
    return s;
  endfunction

  function automatic void model(inout int c, input int maxc, input int digits, input bit en,
                                input bit up, input bit ld, input logic [31:0] lv,
                                output bit w, output bit e);
    int  val;
    bit  ok;
    w = 1'b0;
    e = 1'b0;
    if (ld) begin
      val = 0;
      ok  = 1'b1;
      for (int d = 0; d < digits; d++) begin
        if (lv[4*d +: 4] > 4'd9) ok = 1'b0;
        val += int'(lv[4*d +: 4]) * (10**d);
      end
      if (ok && val <= maxc) c = val;
      else                   e = 1'b1;
    end else if (en) begin
      if (up) begin
        if (c == maxc) begin c = 0; w = 1'b1; end
        else c++;
      end else begin
        if (c == 0) begin c = maxc; w = 1'b1; end
        else c--;
      end
    end
  endfunction

  task automatic step(input bit e, input bit u, input bit l, input logic [31:0] lv0, input logic [31:0] lv1);
    bit w0, er0, w1, er1;
    @(negedge clk);
    rst = 1'b0;
    b0.en = e; b0.up = u; b0.load = l; b0.load_value = lv0[7:0];
    b1.en = e; b1.up = u; b1.load = l; b1.load_value = lv1[11:0];
    model(c0, 63, 2, e, u, l, lv0, w0, er0);
    model(c1, 999, 3, e, u, l, lv1, w1, er1);
    q.push_back('{c0, c1, w0, er0, w1, er1});
  endtask

  // Reset is asynchronous, so outputs are checked shortly after assertion, before any edge.
  task automatic reset_pulse(input bit e, input bit u);
    @(negedge clk);
    rst = 1'b1;
    b0.en = e; b0.up = u; b0.load = 1'b0;
    b1.en = e; b1.up = u; b1.load = 1'b0;
    c0 = 0;
    c1 = 0;
    #1;
    chk("rst_bcd0",  b0.bcd,  exp_bcd(0, 2));
    chk("rst_seg0",  b0.seg,  exp_seg(0, 2, 1'b1, 1'b0));
    chk("rst_wrap0", b0.wrap, 0);
    chk("rst_err0",  b0.err,  0);
    chk("rst_bcd1",  b1.bcd,  exp_bcd(0, 3));
    chk("rst_seg1",  b1.seg,  exp_seg(0, 3, 1'b0, 1'b1));
    chk("rst_wrap1", b1.wrap, 0);
    chk("rst_err1",  b1.err,  0);
    q.push_back('{0, 0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("bcd0",  b0.bcd,  exp_bcd(x.c0, 2));
        chk("seg0",  b0.seg,  exp_seg(x.c0, 2, 1'b1, 1'b0));
        chk("wrap0", b0.wrap, x.w0);
        chk("err0",  b0.err,  x.e0);
        chk("bcd1",  b1.bcd,  exp_bcd(x.c1, 3));
        chk("seg1",  b1.seg,  exp_seg(x.c1, 3, 1'b0, 1'b1));
        chk("wrap1", b1.wrap, x.w1);
        chk("err1",  b1.err,  x.e1);
      end
    end
  end

  initial begin : stimulus
    b0.en = 1'b0; b0.up = 1'b1; b0.load = 1'b0; b0.load_value = '0;
    b1.en = 1'b0; b1.up = 1'b1; b1.load = 1'b0; b1.load_value = '0;
    reset_pulse(1'b0, 1'b1);

    repeat (64) step(1'b1, 1'b1, 1'b0, 0, 0);
    repeat (4)  step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 32'h45, 32'h045);
    step(1'b1, 1'b1, 1'b1, 32'h64, 32'h3A);
    step(1'b1, 1'b0, 1'b1, 32'h3A, 32'hA00);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 32'h45, 32'h007);
    repeat (3)  step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 32'h37, 32'h037);
    reset_pulse(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0)
        reset_pulse(1'($urandom), 1'($urandom));
      else
        step($urandom_range(3) != 0, 1'($urandom), $urandom_range(9) == 0,
             $urandom_range(255), $urandom_range(4095));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_counter.md
BCD_SEVENSEG_COUNTER -- requirements
Module: bcd_sevenseg_counter

Interface
- REQ-001: Parameter DIGITS, default 2: number of BCD digits; legal range 1..8.
- REQ-002: Parameter MAX_COUNT, default 63: terminal count; legal range 1..(10**DIGITS)-1.
- REQ-003: Parameter ACTIVE_LOW, default 1: 1 means a lit segment drives 0; 0 means a lit segment drives 1.
- REQ-004: Parameter LZ_BLANK, default 0: 1 enables leading-zero blanking.
- REQ-005: clk  input  1  clock; all state updates on its rising edge.
- REQ-006: rst  input  1  reset, asynchronous, active-high.
- REQ-007: en  input  1  count enable; one step per clk edge while high.
- REQ-008: up  input  1  direction: 1 counts up, 0 counts down.
- REQ-009: load  input  1  synchronous load strobe.
- REQ-010: load_value  input  DIGITS*4  BCD value to load; digit 0 (units) is in bits [3:0].
- REQ-011: bcd  output  DIGITS*4  current count in BCD; digit 0 is in bits [3:0].
- REQ-012: seg  output  DIGITS*7  segment drive; digit d occupies [7d+6:7d], ordered a (MSB) to g (LSB).
- REQ-013: wrap  output  1  one-cycle pulse on a terminal-count rollover.
- REQ-014: err  output  1  one-cycle pulse when a load is rejected.

Function
- REQ-015: The count shall be held as DIGITS registered BCD digits; a units carry or borrow shall ripple through the digits within one cycle.
- REQ-016: Precedence per edge shall be load > en > hold.
- REQ-017: If en=1, up=1 and count<MAX_COUNT, the count shall advance by 1.
- REQ-018: If en=1, up=1 and count=MAX_COUNT, the count shall become 0 and wrap shall be 1 in the following cycle.
- REQ-019: If en=1, up=0 and count>0, the count shall decrease by 1.
- REQ-020: If en=1, up=0 and count=0, the count shall become MAX_COUNT and wrap shall be 1 in the following cycle.
- REQ-021: A load shall be accepted only if every nibble is ≤9 and the decimal value is ≤MAX_COUNT.
  - Accepted load: count = load_value on the next edge; en is ignored that cycle; wrap stays 0.
  - Rejected load: count holds; err pulses 1 for one cycle; en is ignored that cycle.
- REQ-022: wrap and err shall be registered and shall be 0 in every cycle not covered by REQ-018, REQ-020 or REQ-021.
- REQ-023: bcd and seg shall be registered and updated on the same edge as the count, so they always reflect the current count (no extra latency).
- REQ-024: Digit encoding with ACTIVE_LOW=1, a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - blank=1111111
  - With ACTIVE_LOW=0, every pattern shall be bitwise inverted.
- REQ-025: With LZ_BLANK=1, every zero digit above the most significant nonzero digit shall show blank; digit 0 shall never be blanked.
- REQ-026: With LZ_BLANK=0, no digit shall ever be blanked.
- REQ-027: A non-BCD digit shall be unreachable; if one is ever present, its segment field shall show blank.
- REQ-028: Changing up while en=1 shall take effect on the next edge, with no dead cycle.

Reset
- REQ-029: While rst=1, regardless of clk:
  - bcd = 0
  - seg = all digits showing 0 (upper digits blank if LZ_BLANK=1)
  - wrap = 0, err = 0
- REQ-030: rst asserted mid-count shall clear the count immediately and suppress any pending wrap or err pulse.
- REQ-031: Counting shall resume on the first rising clk edge after rst deasserts, if en=1.

Verification
- REQ-032: Defaults; en=1, up=1 from reset for 64 cycles -> bcd steps 00..63; seg=0000001_1001111 at count 01; count 63 -> 00 with a single wrap pulse.
- REQ-033: Defaults; en=1, up=0 from 00 -> next bcd=63 with wrap=1; then 62, 61; seg at 60 = 0100000_0000001.
- REQ-034: load_value=8'h45 with load=1 and en=1 together -> bcd=45 next cycle; no increment that cycle; err=0.
- REQ-035: load_value=8'h64 (exceeds MAX) and load_value=8'h3A (non-BCD nibble) -> bcd holds; err pulses once for each.
- REQ-036: DIGITS=3, MAX_COUNT=999, LZ_BLANK=1; load 007 -> digits 2 and 1 blank; count up to 010 -> digit 2 blank, digit 1 shows 1.
- REQ-037: rst pulsed for one cycle at count 37 with en=1, then released -> bcd=00 during rst; bcd=01 after the first edge following release.
